// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_cmd_driver : FIFO-buffered, handshaked command initiator for the ALU.
// Optional macro ALU_SETTLE_WAIT_EN holds operands SETTLE_CYCLES extra cycles.
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
  parameter int DATA_W        = 6,
  parameter int FXN_W         = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DATA_W-1:0]             cmd_a,
  input  logic [DATA_W-1:0]             cmd_b,
  input  logic [FXN_W-1:0]              cmd_fxn,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [FXN_W-1:0]              alu_fxn,
  input  logic [DATA_W-1:0]             alu_x,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_x,
  output logic [FXN_W-1:0]              rsp_fxn,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * DATA_W + FXN_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] head;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic             rsp_done;
  logic             issue_done;

  assign cmd_ready  = (fifo_count != FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_fxn};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef ALU_SETTLE_WAIT_EN
  localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  logic [SET_W-1:0] settle_cnt;

  // Loaded on every entry to ISSUE; capture waits until it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (pop) begin
      settle_cnt <= SET_W'(SETTLE_CYCLES);
    end else if ((state == ISSUE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SET_W'(1);
    end
  end

  assign issue_done = (settle_cnt == '0);
`else
  assign issue_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   if (issue_done)  state_nxt = RESP;
      RESP:    if (rsp_ready)   state_nxt = fifo_empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE:  pop = !fifo_empty;
      ISSUE: capture = issue_done;
      RESP: begin
        rsp_done = rsp_ready;
        pop      = rsp_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // Operand lanes only move on a pop, so they stay frozen through ISSUE and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fxn   <= '0;
      rsp_x     <= '0;
      rsp_fxn   <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (pop) begin
        alu_a   <= head[ENT_W-1 -: DATA_W];
        alu_b   <= head[FXN_W +: DATA_W];
        alu_fxn <= head[FXN_W-1:0];
      end
      if (capture) begin
        rsp_x     <= alu_x;
        rsp_fxn   <= alu_fxn;
        rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver : directed self-checking bench; ALU model is a+b mod 64.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

  localparam int DATA_W        = 6;
  localparam int FXN_W         = 3;
  localparam int FIFO_DEPTH    = 4;
  localparam int SETTLE_CYCLES = 2;
`ifdef ALU_SETTLE_WAIT_EN
  localparam int EXTRA = SETTLE_CYCLES;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [FXN_W-1:0]  cmd_fxn = '0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [FXN_W-1:0]  alu_fxn;
  logic [DATA_W-1:0] alu_x;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_x;
  logic [FXN_W-1:0]  rsp_fxn;
  logic [2:0]        fifo_count;
  logic              busy;

  int checks = 0;
  int errors = 0;

  alu_cmd_driver #(
    .DATA_W(DATA_W), .FXN_W(FXN_W), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fxn(cmd_fxn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fxn(alu_fxn), .alu_x(alu_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_fxn(rsp_fxn),
    .fifo_count(fifo_count), .busy(busy)
  );

  assign alu_x = alu_a + alu_b;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
    cmd_a = a; cmd_b = b; cmd_fxn = f; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    checks++; if ({alu_a, alu_b, alu_fxn, rsp_x, rsp_fxn} !== '0) begin errors++; $display("FAIL rst_regs got %0h exp 0", {alu_a, alu_b, alu_fxn, rsp_x, rsp_fxn}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    #9 rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    drive_cmd(6'd5, 6'd9, 3'b010);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", fifo_count); end
    tick();
    checks++; if ({alu_a, alu_b} !== {6'd5, 6'd9}) begin errors++; $display("FAIL single_operands got %0d/%0d exp 5/9", alu_a, alu_b); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", rsp_valid); end
    repeat (EXTRA) tick();
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", rsp_valid); end
    checks++; if (rsp_x !== 6'd14) begin errors++; $display("FAIL single_x got %0d exp 14", rsp_x); end
    checks++; if (rsp_fxn !== 3'b010) begin errors++; $display("FAIL single_fxn got %0d exp 2", rsp_fxn); end
    tick();
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_done busy/valid got %0b exp 00", {busy, rsp_valid}); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_x [5] = '{6'd3, 6'd7, 6'd11, 6'd15, 6'd19};
    int w;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_cmd(6'(2*i+1), 6'(2*i+2), 3'(i+1));
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL bp_count3 got %0d exp 3", fifo_count); end
    drive_cmd(6'd9, 6'd10, 3'd5);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count4 got %0d exp 4", fifo_count); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b exp 0", cmd_ready); end
    checks++; if ({rsp_valid, rsp_x, rsp_fxn} !== {1'b1, 6'd3, 3'd1}) begin errors++; $display("FAIL bp_first got v%0b x%0d f%0d exp v1 x3 f1", rsp_valid, rsp_x, rsp_fxn); end
    cmd_a = 6'd60; cmd_b = 6'd60; cmd_fxn = 3'd7; cmd_valid = 1'b1;
    repeat (3) tick();
    cmd_valid = 1'b0;
    checks++; if ({fifo_count, rsp_x, alu_a} !== {3'd4, 6'd3, 6'd1}) begin errors++; $display("FAIL bp_hold got cnt%0d x%0d a%0d exp cnt4 x3 a1", fifo_count, rsp_x, alu_a); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = 0;
      while (rsp_valid !== 1'b1 && w < 20) begin tick(); w++; end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout result %0d got none exp valid", i); end
      else if ({rsp_x, rsp_fxn} !== {exp_x[i], 3'(i+1)}) begin
        errors++; $display("FAIL bp_result%0d got x%0d f%0d exp x%0d f%0d", i, rsp_x, rsp_fxn, exp_x[i], i+1);
      end
      tick();
    end
    repeat (4) tick();
    checks++; if ({rsp_valid, fifo_count, busy} !== 5'b0) begin errors++; $display("FAIL bp_no_extra got v%0b cnt%0d busy%0b exp 0 0 0", rsp_valid, fifo_count, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0] exp_f [2] = '{3'd6, 3'd5};
    int w;
    rsp_ready = 1'b0;
    drive_cmd(6'd63, 6'd1, 3'd6);
    drive_cmd(6'd32, 6'd32, 3'd5);
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w = 0;
      while (rsp_valid !== 1'b1 && w < 20) begin tick(); w++; end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_timeout result %0d got none exp valid", i); end
      else if ({rsp_x, rsp_fxn} !== {6'd0, exp_f[i]}) begin
        errors++; $display("FAIL wrap_result%0d got x%0d f%0d exp x0 f%0d", i, rsp_x, rsp_fxn, exp_f[i]);
      end
      tick();
    end
    rsp_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [14:0] q [$];
    logic [14:0] e;
    logic [5:0]  ex;
    int k = 0, w = 0, nres = 0, maxc = 0, bad = 0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    while (fifo_count !== 3'd4 && w < 20) begin
      cmd_a = 6'(k); cmd_b = 6'(k*3); cmd_fxn = 3'(k);
      if (cmd_ready) begin q.push_back({cmd_fxn, cmd_a, cmd_b}); k++; end
      tick(); w++;
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_fill got %0d exp 4", fifo_count); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cmd_a = 6'(k); cmd_b = 6'(k*3); cmd_fxn = 3'(k);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (cmd_ready) begin q.push_back({cmd_fxn, cmd_a, cmd_b}); k++; end
      if (rsp_valid) begin
        e = q.pop_front(); ex = e[11:6] + e[5:0]; nres++;
        if ({rsp_fxn, rsp_x} !== {e[14:12], ex}) bad++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (nres !== 20 / (2 + EXTRA)) begin errors++; $display("FAIL b2b_rate got %0d exp %0d", nres, 20 / (2 + EXTRA)); end
    checks++; if (maxc > 4) begin errors++; $display("FAIL b2b_maxcount got %0d exp <=4", maxc); end
    w = 0;
    while (q.size() != 0 && w < 60) begin
      if (rsp_valid) begin
        e = q.pop_front(); ex = e[11:6] + e[5:0];
        if ({rsp_fxn, rsp_x} !== {e[14:12], ex}) bad++;
      end
      tick(); w++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_scoreboard got %0d wrong results exp 0", bad); end
    checks++; if (q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0d pending busy%0b exp 0 0", q.size(), busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    int w = 0;
    logic seen = 1'b0;
    rsp_ready = 1'b0;
    drive_cmd(6'd10, 6'd11, 3'd1);
    drive_cmd(6'd12, 6'd13, 3'd2);
    drive_cmd(6'd14, 6'd15, 3'd3);
    while (!(rsp_valid === 1'b1 && fifo_count === 3'd2) && w < 20) begin tick(); w++; end
    checks++; if ({rsp_valid, fifo_count} !== {1'b1, 3'd2}) begin errors++; $display("FAIL midrst_setup got v%0b cnt%0d exp v1 cnt2", rsp_valid, fifo_count); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, fifo_count, alu_a, busy} !== '0) begin errors++; $display("FAIL midrst_async got v%0b cnt%0d a%0d busy%0b exp 0", rsp_valid, fifo_count, alu_a, busy); end
    #2 rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale got %0b exp 0", seen); end
    checks++; if ({fifo_count, cmd_ready} !== {3'd0, 1'b1}) begin errors++; $display("FAIL midrst_after got cnt%0d rdy%0b exp cnt0 rdy1", fifo_count, cmd_ready); end
    rsp_ready = 1'b0;
  endtask

`ifdef ALU_SETTLE_WAIT_EN
  task automatic test_settle();
    rsp_ready = 1'b1;
    drive_cmd(6'd7, 6'd8, 3'd0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++; if ({alu_a, rsp_valid} !== {6'd7, 1'b0}) begin errors++; $display("FAIL settle_edge%0d got a%0d v%0b exp a7 v0", e, alu_a, rsp_valid); end
    end
    tick();
    checks++; if ({rsp_valid, rsp_x, alu_a} !== {1'b1, 6'd15, 6'd7}) begin errors++; $display("FAIL settle_capture got v%0b x%0d a%0d exp v1 x15 a7", rsp_valid, rsp_x, alu_a); end
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
`ifdef ALU_SETTLE_WAIT_EN
    test_settle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
